spi_rom_reader: RTL and testbench

- SPI initiator (mode 0: CPOL=0, CPHA=0) that reads one 16-bit word from the 5-bit-addressed SPI ROM responder in this design.
- Takes a parallel read request on the system clock, generates sck/cs_n/mosi, deserialises miso, and returns the word with a done pulse.
- Sits between the on-chip controller and the SPI pads; one transaction per request.

---
 rtl/spi_rom_reader.sv | 141 ++++++++++++++
 tb/tb_spi_rom_reader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_rom_reader.sv
// rtl/spi_rom_reader.sv - SPI mode-0 initiator reading one word from the SPI ROM responder
module spi_rom_reader #(
  parameter int CLK_DIV = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done,
  output logic              busy,
  output logic              sck,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  // One dummy edge, ADDR_W address edges, one memory-read edge, DATA_W data edges.
  localparam int NEDGE = 2 + ADDR_W + DATA_W;
  // Phases inside XFER: a leading low phase, then a high and a low phase per edge.
  // Together with SETUP this keeps cs_n low for (2*NEDGE+2)*CLK_DIV cycles.
  localparam int NPH   = 2 * NEDGE + 1;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW    = $clog2(NPH + 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, GAP} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q;
  logic [PW-1:0]     ph_q;
  logic [ADDR_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mosi_q;
  logic              done_q;
  logic              load;
  logic              xfer_end;
  logic              phase_end;
  logic              last_ph;
  logic              fall;
  logic [PW-1:0]     edge_k;

  assign phase_end = (div_q == DW'(CLK_DIV - 1));
  assign last_ph   = (ph_q == PW'(NPH - 1));
  // Odd phases are sck high; edge number k owns phase 2k-1.
  assign edge_k    = (ph_q >> 1) + PW'(1);
  assign fall      = (state_q == XFER) && phase_end && ph_q[0];

  assign sck     = (state_q == XFER) && ph_q[0];
  assign cs_n    = !((state_q == SETUP) || (state_q == XFER));
  assign busy    = (state_q != IDLE);
  assign mosi    = mosi_q;
  assign done    = done_q;
  assign rdata_o = rdata_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    xfer_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          load    = 1'b1;
        end
      end
      SETUP: begin
        if (phase_end) state_d = XFER;
      end
      XFER: begin
        if (phase_end && last_ph) begin
          state_d  = GAP;
          xfer_end = 1'b1;
        end
      end
      GAP: begin
        if (phase_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clock divider and sck phase counter, parked at zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      ph_q  <= '0;
    end else if (state_q == IDLE) begin
      div_q <= '0;
      ph_q  <= '0;
    end else if (phase_end) begin
      div_q <= '0;
      if ((state_q == XFER) && !last_ph) ph_q <= ph_q + PW'(1);
      else                               ph_q <= '0;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  // Serialise the address and deserialise the data on sck falling transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q   <= '0;
      rx_q   <= '0;
      mosi_q <= 1'b0;
    end else if (load) begin
      tx_q   <= addr_i;
      mosi_q <= 1'b0;
    end else if (fall) begin
      if (edge_k <= PW'(ADDR_W)) begin
        mosi_q <= tx_q[ADDR_W-1];
        tx_q   <= tx_q << 1;
      end else begin
        mosi_q <= 1'b0;
      end
      if ((edge_k >= PW'(ADDR_W + 3)) && (edge_k <= PW'(NEDGE)))
        rx_q <= {rx_q[DATA_W-2:0], miso};
    end
  end

  // Publish the received word with a single-cycle done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= xfer_end;
      if (xfer_end) rdata_q <= rx_q;
    end
  end

endmodule

// File: tb/tb_spi_rom_reader.sv
// tb/tb_spi_rom_reader.sv - self-checking bench for spi_rom_reader with behavioural ROM responders
module tb_spi_rom_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, start1 = 1'b0;
  logic [4:0]  addr0 = '0, addr1 = '0;
  logic [15:0] rdata0, rdata1;
  logic        done0, busy0, sck0, cs_n0, mosi0, miso0;
  logic        done1, busy1, sck1, cs_n1, mosi1, miso1;
  logic        stuck0 = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  spi_rom_reader #(.CLK_DIV(2), .ADDR_W(5), .DATA_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .addr_i(addr0), .rdata_o(rdata0),
    .done(done0), .busy(busy0), .sck(sck0), .cs_n(cs_n0), .mosi(mosi0), .miso(miso0)
  );

  spi_rom_reader #(.CLK_DIV(1), .ADDR_W(5), .DATA_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .addr_i(addr1), .rdata_o(rdata1),
    .done(done1), .busy(busy1), .sck(sck1), .cs_n(cs_n1), .mosi(mosi1), .miso(miso1)
  );

  function automatic logic [15:0] rom_word(input logic [4:0] a);
    return 16'hA500 | {11'd0, a};
  endfunction

  // Responder 0: counts edges per frame, captures the address, drives data.
  int          rk0 = 0;
  logic [4:0]  radr0 = '0;
  logic [15:0] rword0 = '0;
  logic        miso_r0 = 1'b0;
  always @(posedge sck0 or posedge cs_n0) begin
    if (cs_n0) begin
      rk0     <= 0;
      miso_r0 <= 1'b0;
    end else begin
      rk0 <= rk0 + 1;
      if (rk0 + 1 == 1) radr0 <= '0;
      if (rk0 + 1 >= 2 && rk0 + 1 <= 6) radr0 <= {radr0[3:0], mosi0};
      if (rk0 + 1 == 7) rword0 <= rom_word(radr0);
      if (rk0 + 1 >= 8 && rk0 + 1 <= 23) miso_r0 <= rword0[22 - rk0];
    end
  end
  assign miso0 = stuck0 ? 1'b1 : miso_r0;

  // Responder 1.
  int          rk1 = 0;
  logic [4:0]  radr1 = '0;
  logic [15:0] rword1 = '0;
  logic        miso_r1 = 1'b0;
  always @(posedge sck1 or posedge cs_n1) begin
    if (cs_n1) begin
      rk1     <= 0;
      miso_r1 <= 1'b0;
    end else begin
      rk1 <= rk1 + 1;
      if (rk1 + 1 == 1) radr1 <= '0;
      if (rk1 + 1 >= 2 && rk1 + 1 <= 6) radr1 <= {radr1[3:0], mosi1};
      if (rk1 + 1 == 7) rword1 <= rom_word(radr1);
      if (rk1 + 1 >= 8 && rk1 + 1 <= 23) miso_r1 <= rword1[22 - rk1];
    end
  end
  assign miso1 = miso_r1;

  // Cumulative monitors: sck rising edges, cs_n-low cycles, sck-high cycles, done cycles.
  int edges0 = 0, edges1 = 0;
  int low0 = 0, low1 = 0, hi0 = 0, hi1 = 0, dones0 = 0, dones1 = 0;
  always @(posedge sck0) if (!cs_n0) edges0 <= edges0 + 1;
  always @(posedge sck1) if (!cs_n1) edges1 <= edges1 + 1;
  always @(negedge clk) begin
    if (!cs_n0) low0 <= low0 + 1;
    if (!cs_n1) low1 <= low1 + 1;
    if (!cs_n0 && sck0) hi0 <= hi0 + 1;
    if (!cs_n1 && sck1) hi1 <= hi1 + 1;
    if (done0) dones0 <= dones0 + 1;
    if (done1) dones1 <= dones1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One read on unit u (0: CLK_DIV=2, 1: CLK_DIV=1); glitch pulses start mid-transfer.
  task automatic rd(input int u, input logic [4:0] a, input bit glitch, input string tag);
    int cd, e, l, h, d, n;
    bit seen;
    logic [15:0] exp;
    cd   = (u == 0) ? 2 : 1;
    exp  = (u == 0 && stuck0) ? 16'hFFFF : rom_word(a);
    e    = (u == 0) ? edges0 : edges1;
    l    = (u == 0) ? low0 : low1;
    h    = (u == 0) ? hi0 : hi1;
    d    = (u == 0) ? dones0 : dones1;
    @(negedge clk);
    if (u == 0) begin start0 = 1'b1; addr0 = a; end
    else        begin start1 = 1'b1; addr1 = a; end
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      if (glitch && u == 0) start0 = (n == 40);
      if ((u == 0) ? done0 : done1) seen = 1'b1;
    end
    start0 = 1'b0;
    check({tag, "_latency"}, n, 48 * cd + 1);
    check({tag, "_rdata"}, (u == 0) ? rdata0 : rdata1, exp);
    check({tag, "_edges"}, ((u == 0) ? edges0 : edges1) - e, 23);
    check({tag, "_cs_low"}, ((u == 0) ? low0 : low1) - l, 48 * cd);
    check({tag, "_sck_high"}, ((u == 0) ? hi0 : hi1) - h, 23 * cd);
    check({tag, "_mosi_addr"}, (u == 0) ? radr0 : radr1, a);
    @(negedge clk);
    check({tag, "_done_pulse"}, (u == 0) ? done0 : done1, 1'b0);
    n = 0;
    while (((u == 0) ? busy0 : busy1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (glitch) repeat (120) @(negedge clk);
    check({tag, "_done_count"}, ((u == 0) ? dones0 : dones1) - d, 1);
    check({tag, "_rdata_hold"}, (u == 0) ? rdata0 : rdata1, exp);
  endtask

  initial begin
    int n, csh, e;
    bit seen;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n0, 1'b1);
    check("rst_sck", sck0, 1'b0);
    check("rst_mosi", mosi0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_rdata", rdata0, 16'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    rd(0, 5'h13, 1'b0, "rd13");

    // Back-to-back with start held high.
    @(negedge clk);
    start0 = 1'b1;
    addr0  = 5'h00;
    n = 0; seen = 1'b0;
    while (!seen && n < 400) begin @(negedge clk); n++; if (done0) seen = 1'b1; end
    check("b2b_first_rdata", rdata0, 16'hA500);
    addr0 = 5'h1F;
    n = 0; seen = 1'b0; csh = 0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      if (cs_n0 && low0 == low0) csh = csh + ((n < 10) ? 1 : 0);
      if (done0) seen = 1'b1;
    end
    start0 = 1'b0;
    check("b2b_period", n, 99);
    check("b2b_cs_gap_ge2", (csh >= 2) ? 1 : 0, 1);
    check("b2b_second_rdata", rdata0, 16'hA51F);
    n = 0;
    while (busy0 && n < 20) begin @(negedge clk); n++; end

    rd(1, 5'h0A, 1'b0, "div1_0a");
    rd(0, 5'h05, 1'b1, "ignored_start");

    // Asynchronous reset in the middle of the data phase.
    @(negedge clk);
    start0 = 1'b1;
    addr0  = 5'h0C;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    e = edges0;
    n = 0;
    while (edges0 - e < 12 && n < 400) begin @(negedge clk); n++; end
    check("rst_mid_reached_edge12", edges0 - e, 12);
    e = dones0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_cs_n", cs_n0, 1'b1);
    check("rst_mid_sck", sck0, 1'b0);
    check("rst_mid_busy", busy0, 1'b0);
    check("rst_mid_rdata", rdata0, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    check("rst_mid_no_done", dones0 - e, 0);
    rd(0, 5'h07, 1'b0, "after_rst");

    stuck0 = 1'b1;
    rd(0, 5'h01, 1'b0, "miso_stuck");
    stuck0 = 1'b0;
    rd(0, 5'h01, 1'b0, "miso_free");

    for (int i = 0; i < 4; i++) begin
      rd(0, 5'($urandom_range(0, 31)), 1'b0, "rand_div2");
      rd(1, 5'($urandom_range(0, 31)), 1'b0, "rand_div1");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
